// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between the fetch stage and the IF/ID register.
// Holds {pc, inst} pairs; flush drops everything on a redirect.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [2*XLEN-1:0] mem_reg [DEPTH];
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              push, pop;

  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_reg;

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign out_pc   = out_valid ? mem_reg[rd_ptr_reg][2*XLEN-1:XLEN] : '0;
  assign out_inst = out_valid ? mem_reg[rd_ptr_reg][XLEN-1:0]      : '0;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset; a flushed or reset cycle must not write.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem_reg[wr_ptr_reg] <= {in_pc, in_inst};
    end
  end

  // An underflow wraps count past DEPTH, so one bound catches both faults.
  count_in_range: assert property (@(posedge clk) disable iff (rst) count_reg <= CW'(DEPTH))
    else $error("fetch_queue count out of range: %0d", count_reg);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, pass-through, full/wrap, simultaneous
// push/pop, flush priority and mid-stream reset.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0] in_pc, in_inst, out_pc, out_inst;
  logic [CW-1:0]   count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc + 32'h1000_0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst_of(pc);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_inst"}, out_inst, inst_of(pc));
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_pc0"}, out_pc, 32'd0);
    check({tag, "_inst0"}, out_inst, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    check_empty("reset");
    tick();
    check_empty("idle");

    // Single pass, one-cycle latency
    in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'h0050_0093;
    tick();
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_pc", out_pc, 32'h0);
    check("single_inst", out_inst, 32'h0050_0093);
    check("single_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_empty("single_pop");
    $display("single pass done: count=%0d", count);

    // Fill to DEPTH
    push_one(32'h0); push_one(32'h4); push_one(32'h8); push_one(32'hC);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    push_one(32'h10);
    check("full_reject_count", 32'(count), 32'd4);
    check_head("full_head", 32'h0);

    // Pop at full with in_valid high: push must not be accepted
    check("pop1_head", out_pc, 32'h0);
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h10; in_inst = inst_of(32'h10);
    tick();
    in_valid = 1'b0;
    check("pop_at_full_count", 32'(count), 32'd3);
    check("pop_at_full_ready", 32'(in_ready), 32'd1);
    check_head("pop2_head", 32'h4);
    tick();
    out_ready = 1'b0;
    check("after_pops_count", 32'(count), 32'd2);
    $display("fill and pop done: count=%0d head=%h", count, out_pc);

    // Push across the pointer wrap, then drain
    push_one(32'h10); push_one(32'h14);
    check("wrap_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    check_head("drain0", 32'h8);  tick();
    check_head("drain1", 32'hC);  tick();
    check_head("drain2", 32'h10); tick();
    check_head("drain3", 32'h14); tick();
    out_ready = 1'b0;
    check_empty("drained");
    // out_ready on an empty queue must not move pointers
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check_empty("empty_pop_ignored");
    $display("wrap drain done: count=%0d", count);

    // Simultaneous push and pop at count=2
    push_one(32'h100); push_one(32'h104);
    check("sim_pre_count", 32'(count), 32'd2);
    in_valid = 1'b1; in_pc = 32'h20; in_inst = inst_of(32'h20); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("sim_count", 32'(count), 32'd2);
    check_head("sim_head", 32'h104); tick();
    check_head("sim_last", 32'h20);  tick();
    out_ready = 1'b0;
    check_empty("sim_drained");
    $display("simultaneous push/pop done: count=%0d", count);

    // Flush beats push and pop
    push_one(32'h30); push_one(32'h34); push_one(32'h38);
    check("flush_pre_count", 32'(count), 32'd3);
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h3C; in_inst = inst_of(32'h3C);
    tick();
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check_empty("flush");
    push_one(32'h50);
    check("post_flush_count", 32'(count), 32'd1);
    check_head("post_flush_head", 32'h50);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check_empty("post_flush_drained");
    $display("flush done: count=%0d", count);

    // Reset mid-stream together with a push
    push_one(32'h60); push_one(32'h64);
    check("rst_pre_count", 32'(count), 32'd2);
    rst = 1'b1; in_valid = 1'b1; in_pc = 32'h68; in_inst = inst_of(32'h68);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_empty("mid_reset");
    push_one(32'h40);
    check("post_rst_count", 32'(count), 32'd1);
    check_head("post_rst_head", 32'h40);
    $display("mid-stream reset done: count=%0d head=%h", count, out_pc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
